// File: rtl/serial_word_receiver_if.sv
// Serial-receiver bundle: the 1-bit input stream with its framing controls,
// plus the word-side valid/ready handshake and status flags.
//   master : stream producer / word consumer (drives bits, out_ready, clr_overrun)
//   slave  : the receiver (drives out_data, out_valid, busy, overrun)
interface serial_word_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             bit_in;
  logic             bit_valid;
  logic             sof;
  logic             msb_first;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output bit_in, bit_valid, sof, msb_first, out_ready, clr_overrun,
    input  out_data, out_valid, busy, overrun
  );

  modport slave (
    input  bit_in, bit_valid, sof, msb_first, out_ready, clr_overrun,
    output out_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver.
// Reassembles WIDTH-bit words from a 1-bit stream (LSB- or MSB-first, chosen
// on bit 0 of each word), resyncs on sof, and hands completed words to a
// one-entry holding register with a valid/ready handshake. A sticky overrun
// flag records words dropped because the holding register was still full.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_word_receiver_if.slave
//          in : bit_in, bit_valid, sof, msb_first, out_ready, clr_overrun
//          out: out_data[WIDTH-1:0], out_valid, busy, overrun
module serial_word_receiver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_word_receiver_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr;
  logic             order_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             overrun_q;

  logic             start;
  logic             order_nxt;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] sr_nxt;
  logic             complete;
  logic             hold_free;

  // A new word starts on any accepted bit while idle or flagged by sof; the
  // shift base is cleared so a discarded partial word cannot leak into it.
  // Because WIDTH >= 2, a starting bit can never also be the completing bit,
  // which is what makes sof on a would-be last bit restart instead of finish.
  always_comb begin
    start     = (state == IDLE) || bus.sof;
    order_nxt = start ? bus.msb_first : order_q;
    sr_base   = start ? '0 : sr;
    sr_nxt    = order_nxt ? {sr_base[WIDTH-2:0], bus.bit_in}
                          : {bus.bit_in, sr_base[WIDTH-1:1]};
    complete  = bus.bit_valid && !start && (count == CW'(WIDTH - 1));
    hold_free = !out_valid_q || bus.out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      sr          <= '0;
      order_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (bus.bit_valid) begin
        order_q <= order_nxt;
        sr      <= sr_nxt;
        if (complete) begin
          state  <= IDLE;
          count  <= '0;
          busy_q <= 1'b0;
        end else begin
          state  <= SHIFT;
          count  <= start ? CW'(1) : count + CW'(1);
          busy_q <= 1'b1;
        end
      end

      if (complete && hold_free) begin
        out_data_q  <= sr_nxt;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (complete && !hold_free) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH = 4): a per-cycle vector
// table for the stream/handshake scenarios plus a hand-written sequence for
// asynchronous reset mid-word.
module tb_serial_word_receiver;
  localparam int unsigned W = 4;

  logic clk;
  logic rst;

  serial_word_receiver_if #(.WIDTH(W)) bus ();

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         bv;
    logic         b;
    logic         sof;
    logic         msb;
    logic         rdy;
    logic         clr;
    logic         ev;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  function automatic void add(input logic bv, input logic b, input logic sof,
                              input logic msb, input logic rdy, input logic clr,
                              input logic ev, input logic [W-1:0] ed,
                              input logic eb, input logic eo);
    vec_t v;
    v.bv = bv; v.b = b; v.sof = sof; v.msb = msb; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic bv, input logic b, input logic sof,
                       input logic msb, input logic rdy, input logic clr);
    bus.bit_valid   = bv;
    bus.bit_in      = b;
    bus.sof         = sof;
    bus.msb_first   = msb;
    bus.out_ready   = rdy;
    bus.clr_overrun = clr;
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic step(input logic bv, input logic b, input logic sof,
                      input logic msb, input logic rdy, input logic clr);
    drive(bv, b, sof, msb, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic ev,
                           input logic [W-1:0] ed, input logic eb, input logic eo);
    chk({tag, ".out_valid"}, idx, 32'(bus.out_valid), 32'(ev));
    chk({tag, ".out_data"},  idx, 32'(bus.out_data),  32'(ed));
    chk({tag, ".busy"},      idx, 32'(bus.busy),      32'(eb));
    chk({tag, ".overrun"},   idx, 32'(bus.overrun),   32'(eo));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // LSB-first 1,0,1,1 -> D, valid for exactly one cycle
    add(1,1,0,0,1,0, 0,4'h0,1,0);
    add(1,0,0,0,1,0, 0,4'h0,1,0);
    add(1,1,0,0,1,0, 0,4'h0,1,0);
    add(1,1,0,0,1,0, 1,4'hD,0,0);
    add(0,0,0,0,1,0, 0,4'hD,0,0);
    // MSB-first 1,0,1,1 with gaps -> B; msb_first and sof ignored mid-word / without bit_valid
    add(1,1,0,1,1,0, 0,4'hD,1,0);
    add(0,0,0,0,1,0, 0,4'hD,1,0);
    add(1,0,0,0,1,0, 0,4'hD,1,0);
    add(0,0,1,0,1,0, 0,4'hD,1,0);
    add(1,1,0,0,1,0, 0,4'hD,1,0);
    add(0,0,0,0,1,0, 0,4'hD,1,0);
    add(1,1,0,0,1,0, 1,4'hB,0,0);
    add(0,0,0,0,1,0, 0,4'hB,0,0);
    // Backpressure: A held, 5 dropped -> overrun; drain; clear
    add(1,1,0,1,0,0, 0,4'hB,1,0);
    add(1,0,0,1,0,0, 0,4'hB,1,0);
    add(1,1,0,1,0,0, 0,4'hB,1,0);
    add(1,0,0,1,0,0, 1,4'hA,0,0);
    add(1,0,0,1,0,0, 1,4'hA,1,0);
    add(1,1,0,1,0,0, 1,4'hA,1,0);
    add(1,0,0,1,0,0, 1,4'hA,1,0);
    add(1,1,0,1,0,0, 1,4'hA,0,1);
    add(0,0,0,0,1,0, 0,4'hA,0,1);
    add(0,0,0,0,0,1, 0,4'hA,0,0);
    // F held, then a drop coinciding with clr_overrun: set wins
    add(1,1,0,1,0,0, 0,4'hA,1,0);
    add(1,1,0,1,0,0, 0,4'hA,1,0);
    add(1,1,0,1,0,0, 0,4'hA,1,0);
    add(1,1,0,1,0,0, 1,4'hF,0,0);
    add(1,0,0,1,0,0, 1,4'hF,1,0);
    add(1,0,0,1,0,0, 1,4'hF,1,0);
    add(1,0,0,1,0,0, 1,4'hF,1,0);
    add(1,1,0,1,0,1, 1,4'hF,0,1);
    add(0,0,0,0,1,0, 0,4'hF,0,1);
    add(0,0,0,0,0,1, 0,4'hF,0,0);
    // Resync: 2 LSB-first bits, then sof + MSB-first 0,0,1,1 -> 3
    add(1,1,0,0,1,0, 0,4'hF,1,0);
    add(1,1,0,0,1,0, 0,4'hF,1,0);
    add(1,0,1,1,1,0, 0,4'hF,1,0);
    add(1,0,0,1,1,0, 0,4'hF,1,0);
    add(1,1,0,1,1,0, 0,4'hF,1,0);
    add(1,1,0,1,1,0, 1,4'h3,0,0);
    add(0,0,0,0,1,0, 0,4'h3,0,0);
    // sof on the would-be last bit restarts; new word 1,1,0,0 MSB-first -> C
    add(1,1,0,1,0,0, 0,4'h3,1,0);
    add(1,1,0,1,0,0, 0,4'h3,1,0);
    add(1,1,0,1,0,0, 0,4'h3,1,0);
    add(1,1,1,1,0,0, 0,4'h3,1,0);
    add(1,1,0,0,0,0, 0,4'h3,1,0);
    add(1,0,0,0,0,0, 0,4'h3,1,0);
    add(1,0,0,0,0,0, 1,4'hC,0,0);
    add(0,0,0,0,1,0, 0,4'hC,0,0);
    // Hold 6, then back-to-back 9 completing with out_ready: drain+refill
    add(1,0,0,1,0,0, 0,4'hC,1,0);
    add(1,1,0,1,0,0, 0,4'hC,1,0);
    add(1,1,0,1,0,0, 0,4'hC,1,0);
    add(1,0,0,1,0,0, 1,4'h6,0,0);
    add(1,1,0,1,0,0, 1,4'h6,1,0);
    add(1,0,0,0,0,0, 1,4'h6,1,0);
    add(1,0,0,0,0,0, 1,4'h6,1,0);
    add(1,1,0,0,1,0, 1,4'h9,0,0);
    add(0,0,0,0,1,0, 0,4'h9,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].bv, vecs[i].b, vecs[i].sof, vecs[i].msb, vecs[i].rdy, vecs[i].clr);
      check_all("vec", i, vecs[i].ev, vecs[i].ed, vecs[i].eb, vecs[i].eo);
    end

    // Asynchronous reset mid-word with a held word and overrun pending
    step(1,1,0,1,0,0); step(1,0,0,1,0,0); step(1,1,0,1,0,0); step(1,0,0,1,0,0);
    step(1,0,0,1,0,0); step(1,1,0,1,0,0); step(1,0,0,1,0,0); step(1,1,0,1,0,0);
    step(1,1,0,0,0,0); step(1,1,0,0,0,0);
    check_all("pre_rst", 0, 1, 4'hA, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    // Clean LSB-first word 0,1,1,1 -> E
    step(1,0,0,0,1,0);
    check_all("post_rst", 0, 0, 4'h0, 1, 0);
    step(1,1,0,0,1,0);
    step(1,1,0,0,1,0);
    step(1,1,0,0,1,0);
    check_all("post_rst", 3, 1, 4'hE, 0, 0);
    step(0,0,0,0,1,0);
    check_all("post_rst", 4, 0, 4'hE, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
